uart_rx_engine: RTL and testbench
=================================

Name: uart_rx_engine

Overview:
- Parametrised UART receive engine, successor to the fixed-format receiver inside the current UART IP.
- Frame format is runtime-configurable: 5..MDW data bits, five parity modes, 1 or 2 stop bits. Adds break detection and false-start rejection.
- Holds one received word in a valid/ready output buffer with overrun reporting.
- Sits between the rx pad and the RX FIFO/bus wrapper. rx_done is kept for testbench monitoring.

Parameters:
- MDW, 9, maximum data bits per frame (5..9).
- SC, 8, baud ticks per bit (oversampling factor, even, >=4).
- PW, 16, prescaler width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  receiver enable
- rx  in  1  serial input, asynchronous, idle high
- prescaler  in  PW  baud tick every prescaler+1 clk cycles
- data_size  in  4  data bits per frame; 5..MDW valid, other values treated as MDW
- parity_mode  in  3  0 none, 1 odd, 2 even, 3 stick-0, 4 stick-1; 5..7 treated as none
- two_stop  in  1  1 = two stop bits
- rx_data  out  MDW  received word, LSB-aligned, upper bits zero
- rx_valid  out  1  buffer holds a word
- rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
- parity_err  out  1  parity status of the buffered word
- frame_err  out  1  framing status of the buffered word
- break_det  out  1  one-cycle pulse when a break is detected
- overrun  out  1  one-cycle pulse when a completed frame is discarded
- rx_done  out  1  one-cycle pulse at every frame completion

Behaviour:
- Reset:
  - all outputs 0; FSM IDLE; tick counter 0.
  - synchroniser flops reset to 1.
- Input path: rx passes through a 2-flop synchroniser to give rxs.
- Baud tick:
  - down-counter reloads with prescaler, one-cycle tick when it reaches 0.
  - counts only while en=1 and state != IDLE; held at prescaler in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
  - IDLE: rxs falling edge with en=1 -> START; tick and sample counters cleared.
  - START: at tick SC/2, if rxs=1 (false start) -> IDLE with no outputs; if rxs=0 -> DATA, sample counter cleared.
  - DATA: sample every SC ticks, LSB first. After data_size bits -> PARITY if parity enabled, else STOP1.
  - PARITY: sample one bit. Odd: error if XOR(data,bit)=0. Even: error if XOR=1. Stick-0/1: error if bit != 0/1.
  - STOP1: sample; 0 sets frame error. -> STOP2 if two_stop, else complete.
  - STOP2: sample; 0 sets frame error; complete.
- Completion happens in the cycle after the final stop sample tick:
  - rx_done pulses.
  - Break: data all 0, parity bit 0 (if present) and first stop 0. break_det pulses, frame_err is set, FSM -> BRK_WAIT.
  - BRK_WAIT -> IDLE when rxs=1.
  - Any other completion -> IDLE.
- Output buffer:
  - Completion with buffer empty: load data and both error flags; rx_valid=1.
  - Completion with rx_valid=1 and rx_ready=1 in the same cycle: old word consumed, new word loaded, no overrun.
  - Completion with rx_valid=1 and rx_ready=0: new word discarded, old word and flags kept, overrun pulses.
  - Handshake with no completion: rx_valid clears next cycle.
- en=0: FSM returns to IDLE next cycle, frame in progress is dropped silently, buffer and handshake keep working.
- Configuration inputs are sampled only on IDLE->START; changes mid-frame take effect on the next frame.

Optional Feature:
- Macro UART_RX_GLITCH_FILTER_EN.
- Defined:
  - 3-stage shift register after the synchroniser, reset to all 1.
  - The filtered line changes only when all 3 stages agree. Adds 2 cycles of latency; pulses shorter than 3 clk cycles are rejected.
- Undefined: rxs feeds the FSM directly.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum.
  - parity_mode encodings PAR_NONE, PAR_ODD, PAR_EVEN, PAR_STICK0, PAR_STICK1.
  - MDW range limits.
- Sub-module uart_baud_tick: prescaler down-counter, enable and reload logic, tick output.
- All other logic is in uart_rx_engine.

Test Plan:
- Common setup: prescaler=1, SC=8, so one bit = 16 clk cycles.
- 8N1, send 0xA5 -> rx_data=0x0A5, rx_valid=1, both error flags 0; rx_done pulses once; rx_valid rises 1 cycle after the stop sample.
- data_size=9, even parity, send 0x1FF with parity=0 -> rx_data=0x1FF, parity_err=1; repeat with parity=1 -> parity_err=0.
- 8N2, second stop bit driven 0, data 0x3C -> rx_data=0x3C, frame_err=1, no break_det.
- rx held low for 20 bit times -> rx_data=0, frame_err=1, break_det pulses once, no new frame until rx returns high.
- Overrun:
  - rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses at the second completion.
  - Then rx_ready=1 for one cycle coincident with a third completion (0x33) -> rx_data=0x33, no overrun.
- Low glitch on idle line:
  - 2 bit-ticks long (<SC/2) -> no rx_done.
  - With UART_RX_GLITCH_FILTER_EN, a 2-clk-cycle low pulse does not leave IDLE.
  - Assert rst_n=0 mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive engine.
//   rx_state_t : receiver FSM state encoding
//   PAR_*      : parity_mode encodings (values above PAR_STICK1 behave as PAR_NONE)
//   MDW_MIN/MAX: legal range of the maximum data width parameter
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_t;

  localparam logic [2:0] PAR_NONE   = 3'd0;
  localparam logic [2:0] PAR_ODD    = 3'd1;
  localparam logic [2:0] PAR_EVEN   = 3'd2;
  localparam logic [2:0] PAR_STICK0 = 3'd3;
  localparam logic [2:0] PAR_STICK1 = 3'd4;

  localparam int MDW_MIN = 5;
  localparam int MDW_MAX = 9;

endpackage

// File: rtl/uart_rx_engine_baud_tick.sv
// Baud tick generator for the UART receive engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : count enable; while low the counter is held at prescaler
//   prescaler  : tick period is prescaler+1 clk cycles
//   tick       : one-cycle strobe when the down-counter reaches zero
module uart_baud_tick #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic [PW-1:0] prescaler,
  output logic          tick
);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == '0) begin
      cnt <= prescaler;
    end else begin
      cnt <= cnt - PW'(1);
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: runtime-configurable frame (5..MDW data bits, five
// parity modes, 1 or 2 stop bits), break detection, false-start rejection
// and a one-word valid/ready output buffer with overrun reporting.
//   clk, rst_n            : clock, asynchronous active-low reset
//   en                    : receiver enable
//   rx                    : asynchronous serial input, idle high
//   prescaler             : baud tick every prescaler+1 clk cycles
//   data_size, parity_mode, two_stop : frame format, latched at frame start
//   rx_data, rx_valid, rx_ready      : output buffer handshake
//   parity_err, frame_err : status of the buffered word
//   break_det, overrun, rx_done      : one-cycle event pulses
// Build option: define UART_RX_GLITCH_FILTER_EN to insert a majority-free
// glitch filter (line changes only when three consecutive samples agree).
module uart_rx_engine
  import uart_rx_pkg::*;
#(
  parameter int MDW = 9,
  parameter int SC  = 8,
  parameter int PW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           rx,
  input  logic [PW-1:0]  prescaler,
  input  logic [3:0]     data_size,
  input  logic [2:0]     parity_mode,
  input  logic           two_stop,
  output logic [MDW-1:0] rx_data,
  output logic           rx_valid,
  input  logic           rx_ready,
  output logic           parity_err,
  output logic           frame_err,
  output logic           break_det,
  output logic           overrun,
  output logic           rx_done
);

  localparam int TCW = $clog2(SC);

  function automatic logic [3:0] norm_size(input logic [3:0] ds);
    return (ds < 4'(MDW_MIN) || ds > 4'(MDW)) ? 4'(MDW) : ds;
  endfunction

  function automatic logic [2:0] norm_par(input logic [2:0] pm);
    return (pm > PAR_STICK1) ? PAR_NONE : pm;
  endfunction

  function automatic logic par_error(input logic [2:0] pm, input logic acc, input logic pbit);
    case (pm)
      PAR_ODD:    return ~(acc ^ pbit);
      PAR_EVEN:   return acc ^ pbit;
      PAR_STICK0: return pbit;
      PAR_STICK1: return ~pbit;
      default:    return 1'b0;
    endcase
  endfunction

  rx_state_t       state, state_d;
  logic            rx_p0, rx_p1;
  logic            line, line_q;
  logic            tick, samp, samp_mid, start_go, last_data, par_en, data_zero;
  logic [TCW-1:0]  tick_cnt;
  logic [3:0]      bit_cnt;
  logic [3:0]      nbits_q;
  logic [2:0]      pmode_q;
  logic            two_q;
  logic [MDW-1:0]  data_sr;
  logic [MDW-1:0]  data_al;
  logic            par_acc, perr_q, par_zero_q, stop1_q;
  logic            frame_end, brk, ferr;

  // Stage p0/p1: two-flop synchroniser, idle-high reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0  <= 1'b1;
      rx_p1  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      rx_p0  <= rx;
      rx_p1  <= rx_p0;
      line_q <= line;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  // Three-sample window (two history flops plus the synchroniser output);
  // the line only moves once all three agree, otherwise it holds.
  logic [1:0] flt_sh;
  logic       flt_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_sh   <= 2'b11;
      flt_hold <= 1'b1;
    end else begin
      flt_sh   <= {flt_sh[0], rx_p1};
      flt_hold <= line;
    end
  end

  always_comb begin
    line = flt_hold;
    if ({flt_sh, rx_p1} == 3'b111) line = 1'b1;
    else if ({flt_sh, rx_p1} == 3'b000) line = 1'b0;
  end
`else
  always_comb line = rx_p1;
`endif

  uart_baud_tick #(.PW(PW)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (en && (state != ST_IDLE)),
    .prescaler (prescaler),
    .tick      (tick)
  );

  assign start_go  = (state == ST_IDLE) && en && line_q && !line;
  assign samp_mid  = tick && (tick_cnt == TCW'(SC/2 - 1));
  assign samp      = tick && (tick_cnt == TCW'(SC - 1));
  assign last_data = (bit_cnt == nbits_q - 4'd1);
  assign par_en    = (pmode_q != PAR_NONE);
  assign data_zero = (data_sr == '0);
  // Bits were shifted in from the top, so right-align to the configured width
  assign data_al   = data_sr >> (4'(MDW) - nbits_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    frame_end = 1'b0;
    brk       = 1'b0;
    ferr      = 1'b0;
    case (state)
      ST_IDLE:     if (start_go) state_d = ST_START;
      ST_START:    if (samp_mid) state_d = line ? ST_IDLE : ST_DATA;
      ST_DATA:     if (samp && last_data) state_d = par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY:   if (samp) state_d = ST_STOP1;
      ST_STOP1: begin
        if (samp) begin
          if (two_q) begin
            state_d = ST_STOP2;
          end else begin
            frame_end = 1'b1;
            ferr      = !line;
            brk       = data_zero && par_zero_q && !line;
          end
        end
      end
      ST_STOP2: begin
        if (samp) begin
          frame_end = 1'b1;
          ferr      = !stop1_q || !line;
          brk       = data_zero && par_zero_q && !stop1_q;
        end
      end
      ST_BRK_WAIT: if (line) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (frame_end) state_d = brk ? ST_BRK_WAIT : ST_IDLE;
    if (!en)       state_d = ST_IDLE;
  end

  // Bit timing counters; the start bit is re-centred at half a bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start_go) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tick) begin
      if ((state == ST_START && samp_mid) || tick_cnt == TCW'(SC - 1)) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + TCW'(1);
      if (state == ST_DATA && samp) bit_cnt <= bit_cnt + 4'd1;
    end
  end

  // Frame datapath and per-frame configuration snapshot
  always_ff @(posedge clk) begin
    if (start_go) begin
      data_sr    <= '0;
      par_acc    <= 1'b0;
      perr_q     <= 1'b0;
      par_zero_q <= 1'b1;
      stop1_q    <= 1'b1;
      nbits_q    <= norm_size(data_size);
      pmode_q    <= norm_par(parity_mode);
      two_q      <= two_stop;
    end else if (samp) begin
      case (state)
        ST_DATA: begin
          data_sr <= {line, data_sr[MDW-1:1]};
          par_acc <= par_acc ^ line;
        end
        ST_PARITY: begin
          par_zero_q <= !line;
          perr_q     <= par_error(pmode_q, par_acc, line);
        end
        ST_STOP1: stop1_q <= line;
        default: ;
      endcase
    end
  end

  // Output buffer: a completing frame is dropped if the old word is still unread
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      rx_done   <= frame_end;
      break_det <= frame_end && brk;
      overrun   <= 1'b0;
      if (frame_end) begin
        if (!rx_valid || rx_ready) begin
          rx_valid   <= 1'b1;
          rx_data    <= data_al;
          parity_err <= perr_q;
          frame_err  <= ferr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine (MDW=9, SC=8, prescaler=1 -> 16 clk/bit).
module tb_uart_rx_engine;

`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 0;
  logic       rst_n = 0;
  logic       en = 1;
  logic       rx = 1;
  logic [15:0] prescaler = 16'd1;
  logic [3:0] data_size = 4'd8;
  logic [2:0] parity_mode = 3'd0;
  logic       two_stop = 0;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 0;
  logic       parity_err, frame_err, break_det, overrun, rx_done;

  uart_rx_engine #(.MDW(9), .SC(8), .PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rx(rx), .prescaler(prescaler),
    .data_size(data_size), .parity_mode(parity_mode), .two_stop(two_stop),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det),
    .overrun(overrun), .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    bit perr;
    bit ferr;
    bit brk;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0, npass = 0;
  int   cyc = 0, ndone = 0, nbrk = 0, novr = 0, last_done_cyc = 0;
  bit   m_valid = 0;
  int   m_data = 0;
  bit   m_perr = 0, m_ferr = 0;

  task automatic chk(input string nm, input int act, input int req);
    nchk++;
    if (act != req) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    else npass++;
  endtask

  // Frame-level model: what the receiver must report for a frame whose
  // sampled bits are the given values.
  function automatic exp_t model(input int d, input int nb, input int pm, input int pbit,
                                 input int s1, input int two, input int s2);
    exp_t e;
    int   dm  = d & ((1 << nb) - 1);
    int   x   = $countones(dm) & 1;
    bit   pen = (pm >= 1 && pm <= 4);
    e.data = dm;
    case (pm)
      1: e.perr = ((x ^ pbit) == 0);
      2: e.perr = ((x ^ pbit) == 1);
      3: e.perr = (pbit != 0);
      4: e.perr = (pbit != 1);
      default: e.perr = 0;
    endcase
    e.ferr = (s1 == 0) || (two != 0 && s2 == 0);
    e.brk  = (dm == 0) && (!pen || pbit == 0) && (s1 == 0);
    if (e.brk) e.ferr = 1;
    return e;
  endfunction

  // Compare process: tracks the output buffer from the model and checks every cycle
  initial begin
    exp_t e;
    bit   exp_ovr, exp_brk;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        m_valid = 0;
        exp_q.delete();
        chk("reset_outputs", {rx_data, rx_valid, parity_err, frame_err, break_det, overrun, rx_done}, 0);
      end else begin
        exp_ovr = 0;
        exp_brk = 0;
        if (rx_done) begin
          ndone++;
          last_done_cyc = cyc;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            exp_brk = e.brk;
            if (!m_valid || rx_ready) begin
              m_valid = 1; m_data = e.data; m_perr = e.perr; m_ferr = e.ferr;
            end else begin
              exp_ovr = 1;
            end
          end
        end else if (m_valid && rx_ready) begin
          m_valid = 0;
        end
        if (break_det) nbrk++;
        if (overrun) novr++;
        chk("rx_valid", rx_valid, m_valid);
        chk("overrun", overrun, exp_ovr);
        chk("break_det", break_det, exp_brk);
        if (m_valid) begin
          chk("rx_data", rx_data, m_data);
          chk("parity_err", parity_err, m_perr);
          chk("frame_err", frame_err, m_ferr);
        end
      end
    end
  end

  task automatic send(input int d, input int nb, input int pm, input int pbit,
                      input int s1, input int two, input int s2, input bit rdy_pulse);
    int bits[16];
    int n = 0, s, k0 = 0, d0;
    bits[n++] = 0;
    for (int i = 0; i < nb; i++) bits[n++] = (d >> i) & 1;
    if (pm >= 1 && pm <= 4) bits[n++] = pbit;
    bits[n++] = s1;
    if (two != 0) bits[n++] = s2;
    s = n - 2;
    exp_q.push_back(model(d, nb, pm, pbit, s1, two, s2));
    d0 = ndone;
    for (int c = 0; c < 16 * n; c++) begin
      @(negedge clk);
      if (c == 0) begin
        k0 = cyc;
        data_size = 4'(nb);
        parity_mode = 3'(pm);
        two_stop = (two != 0);
      end
      rx = bits[c / 16][0];
      if (rdy_pulse) rx_ready = (c == 26 + 16 * s + LAT);
    end
    @(negedge clk);
    rx = 1;
    rx_ready = rdy_pulse ? 1'b0 : rx_ready;
    repeat (16) @(negedge clk);
    chk("done_count", ndone, d0 + 1);
    chk("done_latency", last_done_cyc - k0, 27 + 16 * s + LAT);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
  endtask

  initial begin
    exp_t e;
    int   d0, b0, k0;

    // Hand-computed pins on the model itself
    e = model('hA5, 8, 0, 0, 1, 0, 1);
    chk("model_a5", {e.data, e.perr, e.ferr, e.brk}, {32'h0A5, 3'b000});
    e = model('h1FF, 9, 2, 0, 1, 0, 1);
    chk("model_even_err", e.perr, 1);
    e = model('h1FF, 9, 2, 1, 1, 0, 1);
    chk("model_even_ok", e.perr, 0);
    e = model(0, 8, 0, 0, 0, 0, 0);
    chk("model_break", {e.ferr, e.brk}, 2'b11);
    e = model('h3C, 8, 0, 0, 1, 1, 0);
    chk("model_stop2", {e.ferr, e.brk}, 2'b10);

    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);

    // 8N1 0xA5
    send('hA5, 8, 0, 0, 1, 0, 1, 0);
    chk("a5_word", {rx_valid, rx_data, parity_err, frame_err}, {1'b1, 9'h0A5, 2'b00});
    consume();

    // 9 bits, even parity
    send('h1FF, 9, 2, 0, 1, 0, 1, 0);
    chk("even_bad", {rx_data, parity_err}, {9'h1FF, 1'b1});
    consume();
    send('h1FF, 9, 2, 1, 1, 0, 1, 0);
    chk("even_good", {rx_data, parity_err}, {9'h1FF, 1'b0});
    consume();

    // 8N2 with second stop low
    b0 = nbrk;
    send('h3C, 8, 0, 0, 1, 1, 0, 0);
    chk("stop2_ferr", {rx_data, frame_err}, {9'h03C, 1'b1});
    chk("stop2_nobrk", nbrk, b0);
    consume();

    // Break: line low for 20 bit times
    data_size = 4'd8; parity_mode = 3'd0; two_stop = 0;
    exp_q.push_back(model(0, 8, 0, 0, 0, 0, 0));
    d0 = ndone; b0 = nbrk;
    @(negedge clk);
    k0 = cyc;
    rx = 0;
    repeat (319) @(negedge clk);
    chk("brk_done_once", ndone, d0 + 1);
    chk("brk_pulse_once", nbrk, b0 + 1);
    chk("brk_latency", last_done_cyc - k0, 27 + 16 * 8 + LAT);
    chk("brk_word", {rx_data, frame_err}, {9'h000, 1'b1});
    rx = 1;
    repeat (32) @(negedge clk);
    chk("brk_no_new_frame", ndone, d0 + 1);
    consume();

    // Glitches on the idle line
    d0 = ndone;
    @(negedge clk); rx = 0;
    repeat (4) @(negedge clk); rx = 1;
    repeat (48) @(negedge clk);
    rx = 0;
    repeat (2) @(negedge clk); rx = 1;
    repeat (48) @(negedge clk);
    chk("glitch_no_done", ndone, d0);

    // Overrun, then completion coincident with a handshake
    b0 = novr;
    send('h11, 8, 0, 0, 1, 0, 1, 0);
    send('h22, 8, 0, 0, 1, 0, 1, 0);
    chk("ovr_keep_old", {rx_valid, rx_data}, {1'b1, 9'h011});
    chk("ovr_pulse", novr, b0 + 1);
    send('h33, 8, 0, 0, 1, 0, 1, 1);
    chk("handshake_load", {rx_valid, rx_data}, {1'b1, 9'h033});
    chk("handshake_no_ovr", novr, b0 + 1);

    // Reset in the middle of a frame
    @(negedge clk); rx = 0;
    repeat (40) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midframe_reset", {rx_data, rx_valid, parity_err, frame_err, break_det, overrun, rx_done}, 0);
    @(negedge clk); rx = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    chk("post_reset_idle", {rx_valid, ndone}, {1'b0, d0 + 3});

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
